// File: rtl/instruction_cache_miss_controller_if.sv
// Memory read bus between the instruction-cache miss controller (master) and memory (slave).
// Single outstanding read; request held until accepted, data returned on a one-cycle strobe.
interface instruction_cache_miss_controller_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int BUS_WIDTH  = 32
);
  logic [ADDR_WIDTH-1:0] mem_address;
  logic                  mem_read;
  logic                  mem_waitrequest;
  logic [BUS_WIDTH-1:0]  mem_readdata;
  logic                  mem_readdatavalid;

  modport master (
    output mem_address, mem_read,
    input  mem_waitrequest, mem_readdata, mem_readdatavalid
  );

  modport slave (
    input  mem_address, mem_read,
    output mem_waitrequest, mem_readdata, mem_readdatavalid
  );
endinterface

// File: rtl/instruction_cache_miss_controller.sv
// Instruction-cache line fill: fetches a line one bus word per read and pulses done when assembled.
// Optional macro CRITICAL_WORD_FIRST_EN starts the fill at the missing word and wraps.
//
// state | meaning
// IDLE  | waiting for miss, samples miss_address
// REQ   | issue read for current beat, hold until accepted
// RESP  | wait for read data, store into its word slot
// DONE  | done pulse, line complete
// CLEAR | wait for miss to drop before accepting a new request
module instruction_cache_miss_controller #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 128,
  parameter int BUS_WIDTH  = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  miss,
  input  logic [ADDR_WIDTH-1:0] miss_address,
  output logic [LINE_WIDTH-1:0] miss_data,
  output logic                  done,
  instruction_cache_miss_controller_if.master bus
);

  localparam int BEATS    = LINE_WIDTH / BUS_WIDTH;
  localparam int IDX_W    = $clog2(BEATS);
  localparam int WORD_LSB = $clog2(BUS_WIDTH / 8);
  localparam int LINE_LSB = $clog2(LINE_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(LINE_WIDTH / 8 - 1);
  localparam logic [IDX_W-1:0]      LAST_BEAT = IDX_W'(BEATS - 1);

  typedef enum logic [2:0] {IDLE, REQ, RESP, DONE, CLEAR} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] base;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      cnt;
  logic [IDX_W-1:0]      first_idx;
  logic [ADDR_WIDTH-1:0] beat_addr;

  // Base is line aligned, so OR-ing the word offset equals base + idx*word_bytes.
  assign beat_addr = base | ({{(ADDR_WIDTH-IDX_W){1'b0}}, idx} << WORD_LSB);

`ifdef CRITICAL_WORD_FIRST_EN
  assign first_idx = miss_address[LINE_LSB-1:WORD_LSB];
`else
  assign first_idx = '0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      base            <= '0;
      idx             <= '0;
      cnt             <= '0;
      miss_data       <= '0;
      done            <= 1'b0;
      bus.mem_read    <= 1'b0;
      bus.mem_address <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss) begin
            base  <= miss_address & LINE_MASK;
            idx   <= first_idx;
            cnt   <= '0;
            state <= REQ;
          end
        end
        REQ: begin
          if (!bus.mem_read) begin
            bus.mem_read    <= 1'b1;
            bus.mem_address <= beat_addr;
          end else if (!bus.mem_waitrequest) begin
            bus.mem_read <= 1'b0;
            state        <= RESP;
          end
        end
        RESP: begin
          if (bus.mem_readdatavalid) begin
            miss_data[int'(idx)*BUS_WIDTH +: BUS_WIDTH] <= bus.mem_readdata;
            if (cnt == LAST_BEAT) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              cnt   <= cnt + 1'b1;
              idx   <= idx + 1'b1;
              state <= REQ;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= CLEAR;
        end
        CLEAR: begin
          if (!miss) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
